// File: rtl/snake_pkg.sv
// Shared constants, direction codes and FSM encoding for the snake game controller.
package snake_pkg;

  localparam int GRID_W   = 64;
  localparam int GRID_H   = 48;
  localparam int MAX_LEN  = 15;
  localparam int INIT_LEN = 2;
  localparam int X_W      = 7;
  localparam int Y_W      = 6;
  localparam int LEN_W    = 4;

  localparam logic [4:0] DIR_RIGHT = 5'b00001;
  localparam logic [4:0] DIR_DOWN  = 5'b00010;
  localparam logic [4:0] DIR_LEFT  = 5'b00100;
  localparam logic [4:0] DIR_UP    = 5'b01000;
  localparam logic [4:0] DIR_STOP  = 5'b10000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_CHECK,
    ST_OVER
  } state_t;

  function automatic logic [4:0] reverse_dir(input logic [4:0] dir);
    case (dir)
      DIR_RIGHT: reverse_dir = DIR_LEFT;
      DIR_LEFT:  reverse_dir = DIR_RIGHT;
      DIR_DOWN:  reverse_dir = DIR_UP;
      DIR_UP:    reverse_dir = DIR_DOWN;
      default:   reverse_dir = DIR_STOP;
    endcase
  endfunction

endpackage

// File: rtl/snake_if.sv
// Controller <-> movement datapath bundle: move strobes out, head/tail/food positions back.
interface snake_if;
  import snake_pkg::*;

  logic [4:0]             direction;
  logic                   step;
  logic                   dp_clr;
  logic                   food_req;
  logic [X_W-1:0]         head_x;
  logic [Y_W-1:0]         head_y;
  logic [MAX_LEN*X_W-1:0] tail_x;
  logic [MAX_LEN*Y_W-1:0] tail_y;
  logic [X_W-1:0]         food_x;
  logic [Y_W-1:0]         food_y;

  modport master (
    output direction, step, dp_clr, food_req,
    input  head_x, head_y, tail_x, tail_y, food_x, food_y
  );

  modport slave (
    input  direction, step, dp_clr, food_req,
    output head_x, head_y, tail_x, tail_y, food_x, food_y
  );

endinterface

// File: rtl/snake_hit_detect.sv
// Combinational wall / self / food collision check on the current head position.
module snake_hit_detect
  import snake_pkg::*;
(
  input  logic [X_W-1:0]         head_x,
  input  logic [Y_W-1:0]         head_y,
  input  logic [MAX_LEN*X_W-1:0] tail_x,
  input  logic [MAX_LEN*Y_W-1:0] tail_y,
  input  logic [LEN_W-1:0]       length,
  input  logic [X_W-1:0]         food_x,
  input  logic [Y_W-1:0]         food_y,
  output logic                   wall_hit,
  output logic                   self_hit,
  output logic                   food_hit
);

  always_comb begin
    // Moving off the low edge wraps to 127/63, so one upper-bound compare covers both sides.
    wall_hit = (head_x >= X_W'(GRID_W)) || (head_y >= Y_W'(GRID_H));
    food_hit = (head_x == food_x) && (head_y == food_y);
    self_hit = 1'b0;
    // Segment 0 is where the head just came from and can never collide.
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((LEN_W'(i) < length) &&
          (tail_x[i*X_W +: X_W] == head_x) &&
          (tail_y[i*Y_W +: Y_W] == head_y)) begin
        self_hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snake_ctrl.sv
// Snake game sequencer: step timer, direction filter, post-step hit handling, length/score.
//
// state    | meaning
// ST_IDLE  | after reset, waiting for start, direction stop
// ST_RUN   | timer counting, step issued at terminal count
// ST_CHECK | one cycle after step, head examined for hits
// ST_OVER  | game lost, counters frozen, waiting for start
module snake_ctrl
  import snake_pkg::*;
#(
  parameter int STEP_TICKS = 15165696
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       btn_dir,
  input  logic             start,
  snake_if.master          dp,
  output logic [LEN_W-1:0] length,
  output logic [7:0]       score,
  output logic             game_over
);

  localparam int TMR_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [TMR_W-1:0] TC     = TMR_W'(STEP_TICKS - 1);
  localparam logic [TMR_W-1:0] TC_PRE = TMR_W'(STEP_TICKS - 2);

  state_t           state;
  logic [4:0]       committed;
  logic [4:0]       pending;
  logic [TMR_W-1:0] timer;
  logic             wall_hit;
  logic             self_hit;
  logic             food_hit;
  logic [4:0]       btn_req;
  logic             btn_ok;
  logic             running;

  snake_hit_detect u_hit (
    .head_x   (dp.head_x),
    .head_y   (dp.head_y),
    .tail_x   (dp.tail_x),
    .tail_y   (dp.tail_y),
    .length   (length),
    .food_x   (dp.food_x),
    .food_y   (dp.food_y),
    .wall_hit (wall_hit),
    .self_hit (self_hit),
    .food_hit (food_hit)
  );

  // Reversal is judged against the committed direction so two quick presses cannot U-turn.
  assign btn_req = {1'b0, btn_dir};
  assign btn_ok  = $onehot(btn_dir) && (btn_req != reverse_dir(committed));
  assign running = (state == ST_RUN) || (state == ST_CHECK);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      committed    <= DIR_RIGHT;
      pending      <= DIR_RIGHT;
      timer        <= '0;
      dp.direction <= DIR_STOP;
      dp.step      <= 1'b0;
      dp.dp_clr    <= 1'b0;
      dp.food_req  <= 1'b0;
      length       <= LEN_W'(INIT_LEN);
      score        <= '0;
      game_over    <= 1'b0;
    end else begin
      dp.step     <= 1'b0;
      dp.dp_clr   <= 1'b0;
      dp.food_req <= 1'b0;
      if (running && btn_ok) begin
        pending <= btn_req;
      end
      case (state)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            state        <= ST_RUN;
            dp.dp_clr    <= 1'b1;
            timer        <= '0;
            committed    <= DIR_RIGHT;
            pending      <= DIR_RIGHT;
            dp.direction <= DIR_RIGHT;
            length       <= LEN_W'(INIT_LEN);
            score        <= '0;
            game_over    <= 1'b0;
          end
        end
        ST_RUN: begin
          if (timer == TC) begin
            timer        <= '0;
            committed    <= pending;
            dp.direction <= pending;
            state        <= ST_CHECK;
          end else begin
            timer   <= timer + 1'b1;
            dp.step <= (timer == TC_PRE);
          end
        end
        ST_CHECK: begin
          timer <= timer + 1'b1;
          if (wall_hit || self_hit) begin
            state        <= ST_OVER;
            game_over    <= 1'b1;
            dp.direction <= DIR_STOP;
          end else begin
            state   <= ST_RUN;
            dp.step <= (timer == TC_PRE);
            if (food_hit) begin
              dp.food_req <= 1'b1;
              if (length != LEN_W'(MAX_LEN)) length <= length + 1'b1;
              if (score != 8'hFF) score <= score + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_ctrl.sv
// Randomized bench for snake_ctrl against a period/phase-based game model.
module tb_snake_ctrl;
  import snake_pkg::*;

  localparam int P = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_dir;
  logic       start;
  logic [3:0] length;
  logic [7:0] score;
  logic       game_over;

  snake_if dpi ();

  snake_ctrl #(.STEP_TICKS(P)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_dir   (btn_dir),
    .start     (start),
    .dp        (dpi),
    .length    (length),
    .score     (score),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: mode 0 idle, 1 playing, 2 over; n = cycles since the game started.
  int         mode;
  int         n;
  int         m_len;
  int         m_score;
  logic [4:0] m_com;
  logic [4:0] m_pend;
  bit         e_clr;
  bit         e_food;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] opposite(input logic [4:0] d);
    int idx;
    idx = -1;
    for (int b = 0; b < 4; b++) if (d[b]) idx = b;
    if (idx < 0) return 5'b10000;
    return 5'(1 << ((idx + 2) % 4));
  endfunction

  task automatic model_reset();
    mode = 0; n = 0; m_len = 2; m_score = 0;
    m_com = 5'b00001; m_pend = 5'b00001;
    e_clr = 0; e_food = 0;
  endtask

  task automatic model_edge();
    logic [4:0] req;
    logic [4:0] next_pend;
    bit wall, selfh, food, is_step, is_check;
    e_clr = 0; e_food = 0;
    if (mode != 1) begin
      if (start) begin
        mode = 1; n = 0; m_len = 2; m_score = 0;
        m_com = 5'b00001; m_pend = 5'b00001; e_clr = 1;
      end
    end else begin
      is_step  = (n % P) == P - 1;
      is_check = (n > 0) && ((n % P) == 0);
      req = {1'b0, btn_dir};
      next_pend = m_pend;
      if ($countones(btn_dir) == 1 && req != opposite(m_com)) next_pend = req;
      if (is_step) m_com = m_pend;
      m_pend = next_pend;
      if (is_check) begin
        wall  = (int'(dpi.head_x) > 63) || (int'(dpi.head_y) > 47);
        food  = (dpi.head_x == dpi.food_x) && (dpi.head_y == dpi.food_y);
        selfh = 0;
        for (int i = 1; i < m_len; i++)
          if (dpi.tail_x[7*i +: 7] == dpi.head_x && dpi.tail_y[6*i +: 6] == dpi.head_y) selfh = 1;
        if (wall || selfh) mode = 2;
        else if (food) begin
          e_food = 1;
          if (m_len < 15) m_len++;
          if (m_score < 255) m_score++;
        end
      end
      n++;
    end
  endtask

  task automatic compare_all();
    check_val("direction", 32'(dpi.direction), 32'((mode == 1) ? m_com : 5'b10000));
    check_val("step", 32'(dpi.step), 32'(mode == 1 && (n % P) == P - 1));
    check_val("dp_clr", 32'(dpi.dp_clr), 32'(e_clr));
    check_val("food_req", 32'(dpi.food_req), 32'(e_food));
    check_val("length", 32'(length), 32'(m_len));
    check_val("score", 32'(score), 32'(m_score));
    check_val("game_over", 32'(game_over), 32'(mode == 2));
  endtask

  task automatic drive(input bit food_heavy);
    int r;
    int k;
    r = $urandom_range(0, 9);
    if (r < 4) btn_dir = 4'b0000;
    else if (r < 8) btn_dir = 4'(1 << $urandom_range(0, 3));
    else btn_dir = 4'($urandom);
    start = ($urandom_range(0, 99) < ((mode == 1) ? 3 : 25));
    for (int i = 0; i < 15; i++) begin
      dpi.tail_x[7*i +: 7] = 7'($urandom_range(0, 63));
      dpi.tail_y[6*i +: 6] = food_heavy ? 6'($urandom_range(24, 47)) : 6'($urandom_range(0, 47));
    end
    dpi.food_x = 7'($urandom_range(0, 63));
    dpi.food_y = food_heavy ? 6'($urandom_range(0, 23)) : 6'($urandom_range(0, 47));
    r = food_heavy ? 50 : $urandom_range(0, 99);
    if (r < 30) begin
      dpi.head_x = 7'($urandom_range(0, 63));
      dpi.head_y = 6'($urandom_range(0, 47));
    end else if (r < 45) begin
      if ($urandom_range(0, 1) == 1) begin
        dpi.head_x = 7'($urandom_range(64, 127));
        dpi.head_y = 6'($urandom_range(0, 47));
      end else begin
        dpi.head_x = 7'($urandom_range(0, 63));
        dpi.head_y = 6'($urandom_range(48, 63));
      end
    end else if (r < 65) begin
      dpi.head_x = dpi.food_x;
      dpi.head_y = dpi.food_y;
    end else begin
      k = $urandom_range(0, 14);
      dpi.head_x = dpi.tail_x[7*k +: 7];
      dpi.head_y = dpi.tail_y[6*k +: 6];
    end
  endtask

  task automatic run_cycle(input bit food_heavy);
    @(negedge clk);
    drive(food_heavy);
    @(posedge clk);
    model_edge();
    #1 compare_all();
  endtask

  task automatic reset_test();
    int waited;
    waited = 0;
    while (!(mode == 1 && (n % P) == 2) && waited < 200) begin
      run_cycle(0);
      waited++;
    end
    check_val("reset_wait_timer2", 32'(mode == 1 && (n % P) == 2), 32'd1);
    #2 reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 compare_all();
    end
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    btn_dir = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      model_edge();
      #1 compare_all();
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    btn_dir = 4'b0000;
    dpi.head_x = '0; dpi.head_y = '0;
    dpi.tail_x = '0; dpi.tail_y = '0;
    dpi.food_x = '0; dpi.food_y = '0;
    model_reset();
    #12 compare_all();
    @(negedge clk);
    reset = 1'b0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      run_cycle(cyc >= 1500 && cyc < 4500);
      if (cyc == 1000 || cyc == 5000) reset_test();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/snake_ctrl.md
Name: snake_ctrl

Overview:
Game-sequencing controller for the snake movement datapath. It owns the step timer and issues one step pulse per move period. It filters keyboard direction requests and presents a one-hot direction code to the movement datapath. After every step it checks the new head for wall, self and food hits, and manages snake length, score and game-over.

Parameters:
STEP_TICKS, 15165696, clk cycles between step pulses (about 0.23 s at 65 MHz)
GRID_W, 64, playfield width in cells; valid x is 0..GRID_W-1
GRID_H, 48, playfield height in cells; valid y is 0..GRID_H-1
MAX_LEN, 15, number of tail segments the datapath holds
INIT_LEN, 2, tail length after restart

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
btn_dir  in  4  direction request, bit0 right, bit1 down, bit2 left, bit3 up; level-sensitive
start  in  1  start/restart request, single-cycle pulse
head_x  in  7  head x from the datapath
head_y  in  6  head y from the datapath
tail_x  in  105  15 x 7-bit tail x; segment i is bits [7i+6:7i]; segment 0 is the newest
tail_y  in  90  15 x 6-bit tail y; segment i is bits [6i+5:6i]
food_x  in  7  current food cell x
food_y  in  6  current food cell y
direction  out  5  one-hot to the datapath: 00001 right, 00010 down, 00100 left, 01000 up, 10000 stop
step  out  1  one-cycle move strobe to the datapath
dp_clr  out  1  one-cycle pulse that returns the datapath to its start position
food_req  out  1  one-cycle pulse requesting a new food cell
length  out  4  active tail segments
score  out  8  food eaten, saturates at 255
game_over  out  1  high in OVER state

Behaviour:
- Reset values: state IDLE, direction 10000, committed and pending direction right (00001), step 0, dp_clr 0, food_req 0, length INIT_LEN, score 0, game_over 0, timer 0.
- FSM states:
  - IDLE: direction=10000, timer held at 0. On start: dp_clr pulse, length=INIT_LEN, score=0, pending=right, then go to RUN on the next cycle.
  - RUN: direction = committed direction. The timer counts 0..STEP_TICKS-1. At the terminal count: step=1 for that cycle, committed<=pending, timer wraps to 0, go to CHECK.
  - CHECK: lasts exactly one cycle; the head has updated on the clock edge that consumed step. Priority order:
    1. Wall hit: head_x >= GRID_W or head_y >= GRID_H. Underflow wraps to 127/63, so it is caught by the same compare. Go to OVER.
    2. Self hit: head equals any segment i, 1 <= i < length. Go to OVER.
    3. Food hit: head == food. food_req pulse; length<=min(length+1, MAX_LEN); score<=min(score+1, 255).
    - Otherwise return to RUN. Timer keeps counting in CHECK, so the step period is exactly STEP_TICKS.
  - OVER: direction=10000, game_over=1, all counters frozen. On start: dp_clr pulse, reinitialise as in IDLE, then go to RUN.
- Latency: step at cycle T, head visible at T+1 (CHECK), game_over or food_req at T+2.
- Direction filter, evaluated every cycle in RUN and CHECK:
  - btn_dir must be exactly one-hot; zero bits or multiple bits are ignored.
  - A request for the reverse of the committed direction is ignored.
  - Otherwise pending<=request.
  - Filtering compares against committed, not pending, so two quick presses cannot produce a reversal.
- Simultaneous events: if btn_dir and the terminal count occur in the same cycle, the step uses the old pending value and the new request applies to the next step.
- Reset asserted mid-game: asynchronous return to all reset values; no pulse outputs are generated.
- start is ignored in RUN and CHECK.

Decomposition:
- Shared package snake_pkg holds:
  - direction codes DIR_RIGHT, DIR_DOWN, DIR_LEFT, DIR_UP, DIR_STOP;
  - GRID_W, GRID_H, MAX_LEN, segment widths 7 and 6;
  - FSM state encoding and a reverse-direction function.
- One sub-module is natural: snake_hit_detect.
  - Purely combinational.
  - Inputs: head, tail arrays, length, food.
  - Outputs: wall_hit, self_hit, food_hit.
  - Instantiated once; the controller FSM and timer remain in snake_ctrl.

Test Plan:
1. STEP_TICKS=4, start, no buttons -> dp_clr at cycle 1; step every 4 cycles; direction=00001; length=2, score=0.
2. Committed right, btn_dir=0100 (left) -> ignored, direction stays 00001. Then btn_dir=0010 -> next step has direction 00010; a following 1000 before that step is also ignored.
3. Head driven to x=64 (or y=63 after moving up from 0) in CHECK -> game_over=1 at T+2, direction=10000, step stops; start -> dp_clr, RUN, score=0.
4. Head == food (10,5) in CHECK -> food_req pulse at T+2, length 2->3, score 0->1. Repeat with length=15 -> length stays 15, score increments.
5. length=4, head equals segment 3 -> game_over. Head equals segment 5 (inactive) -> no game_over.
6. Reset asserted mid-RUN with the timer at 2 -> all outputs return to reset values immediately. After deassert: IDLE, no step until start.
